gcd_sub_engine: RTL and testbench



---
 rtl/gcd_sub_engine.sv | 177 +++++++++++++++++
 tb/tb_gcd_sub_engine.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gcd_sub_engine.sv
// Iterative subtraction-based GCD engine with valid/ready operand and result handshakes.
// Optional macro GCD_ITER_COUNT_EN adds the saturating iter_count output.

// One bit of the ripple-borrow subtractor: d = a - b - bin.
module full_subt (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow-out of a single subtractor stage
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

module gcd_sub_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [WIDTH:0]   iter_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] gcd_r;
  logic [WIDTH-1:0] a_nxt_s;
  logic [WIDTH-1:0] b_nxt_s;
  logic [WIDTH-1:0] gcd_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [WIDTH-1:0] diff_s;
  logic [WIDTH:0]   borrow_s;
  logic             borrow_out_s;
  logic             accept_s;
  logic             run_term_s;

  // The subtractor's final borrow doubles as the A<B comparator.
  assign borrow_s[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sub
      full_subt u_cell (
        .a    (a_r[gi]),
        .b    (b_r[gi]),
        .bin  (borrow_s[gi]),
        .d    (diff_s[gi]),
        .bout (borrow_s[gi+1])
      );
    end
  endgenerate

  assign borrow_out_s = borrow_s[WIDTH];

  // Accept strobe and detection of a terminal RUN decision (rules 1-3)
  always_comb begin
    accept_s   = (state_r == ST_IDLE) && in_valid && in_ready_r;
    run_term_s = (b_r == {WIDTH{1'b0}}) || (a_r == {WIDTH{1'b0}}) ||
                 ((diff_s == {WIDTH{1'b0}}) && !borrow_out_s);
  end

  // Next-state and datapath decisions, one per clock in RUN
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    gcd_nxt_s   = gcd_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          a_nxt_s     = a_in;
          b_nxt_s     = b_in;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (b_r == {WIDTH{1'b0}}) begin
          gcd_nxt_s   = a_r;
          state_nxt_s = ST_DONE;
        end else if (a_r == {WIDTH{1'b0}}) begin
          gcd_nxt_s   = b_r;
          state_nxt_s = ST_DONE;
        end else if ((diff_s == {WIDTH{1'b0}}) && !borrow_out_s) begin
          gcd_nxt_s   = a_r;
          state_nxt_s = ST_DONE;
        end else if (!borrow_out_s) begin
          a_nxt_s     = diff_s;
          state_nxt_s = ST_RUN;
        end else begin
          a_nxt_s     = b_r;
          b_nxt_s     = a_r;
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, operand and result registers; handshake flags registered from next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      gcd_r       <= {WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      a_r         <= a_nxt_s;
      b_r         <= b_nxt_s;
      gcd_r       <= gcd_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign gcd_out   = gcd_r;

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH:0] iter_cnt_r;

  // Non-terminal iteration counter, cleared on accept and saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_cnt_r <= {(WIDTH+1){1'b0}};
    end else if (accept_s) begin
      iter_cnt_r <= {(WIDTH+1){1'b0}};
    end else if ((state_r == ST_RUN) && !run_term_s && !(&iter_cnt_r)) begin
      iter_cnt_r <= iter_cnt_r + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      iter_cnt_r <= iter_cnt_r;
    end
  end

  assign iter_count = iter_cnt_r;
`endif

endmodule

// File: tb/tb_gcd_sub_engine.sv
// Directed-vector bench for gcd_sub_engine (8-bit and 4-bit instances).
// iter_count is checked when GCD_ITER_COUNT_EN is defined; latency is always checked.
module tb_gcd_sub_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a_in, b_in, gcd_out;
  logic       in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0] a_in4, b_in4, gcd_out4;
`ifdef GCD_ITER_COUNT_EN
  logic [8:0] iter_count;
  logic [4:0] iter_count4;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clk = ~clk;

  gcd_sub_engine #(.WIDTH(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .gcd_out    (gcd_out)
`ifdef GCD_ITER_COUNT_EN
    ,
    .iter_count (iter_count)
`endif
  );

  gcd_sub_engine #(.WIDTH(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid4),
    .in_ready   (in_ready4),
    .a_in       (a_in4),
    .b_in       (b_in4),
    .out_valid  (out_valid4),
    .out_ready  (out_ready4),
    .gcd_out    (gcd_out4)
`ifdef GCD_ITER_COUNT_EN
    ,
    .iter_count (iter_count4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid on the 8-bit instance, counting edges.
  task automatic wait_done();
    cyc = 0;
    while (!out_valid && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int exp_gcd, input int exp_iter);
    @(negedge clk);
    chk({tag, " in_ready"}, in_ready, 1);
    a_in = a; b_in = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done();
    chk({tag, " latency"}, cyc, exp_iter + 1);
    chk({tag, " gcd"}, gcd_out, exp_gcd);
`ifdef GCD_ITER_COUNT_EN
    chk({tag, " iter"}, iter_count, exp_iter);
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, out_valid, 0);
    chk({tag, " idle in_ready"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a_in = 8'd0; b_in = 8'd0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a_in4 = 4'd0; b_in4 = 4'd0;
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset gcd", gcd_out, 0);
`ifdef GCD_ITER_COUNT_EN
    chk("reset iter", iter_count, 0);
`endif
    @(negedge clk); rst = 1'b0;

    run_op("g12_18", 8'd12, 8'd18, 6, 4);

    // Reset in the middle of a long run
    @(negedge clk);
    a_in = 8'd1; b_in = 8'd255; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrun busy", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("midrst in_ready", in_ready, 1);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst gcd", gcd_out, 0);
`ifdef GCD_ITER_COUNT_EN
    chk("midrst iter", iter_count, 0);
`endif
    @(negedge clk); rst = 1'b0;

    run_op("g9_6", 8'd9, 8'd6, 3, 3);
    run_op("g0_0", 8'd0, 8'd0, 0, 0);
    run_op("g7_0", 8'd7, 8'd0, 7, 0);
    run_op("g0_5", 8'd0, 8'd5, 5, 0);
    run_op("g1_255", 8'd1, 8'd255, 1, 255);

    // 4-bit instance: a=1, b=15 takes 15 iterations
    @(negedge clk);
    a_in4 = 4'd1; b_in4 = 4'd15; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    cyc = 0;
    while (!out_valid4 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("w4 latency", cyc, 16);
    chk("w4 gcd", gcd_out4, 1);
`ifdef GCD_ITER_COUNT_EN
    chk("w4 iter", iter_count4, 15);
`endif
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    chk("w4 idle in_ready", in_ready4, 1);

    // Handshake: stall in DONE while in_valid is pulsed with another pair
    @(negedge clk);
    a_in = 8'd35; b_in = 8'd14; in_valid = 1'b1;
    @(posedge clk); #1;
    a_in = 8'd4; b_in = 8'd2;
    wait_done();
    chk("hs latency", cyc, 5);
    chk("hs gcd", gcd_out, 7);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      chk("hs hold valid", out_valid, 1);
      chk("hs hold gcd", gcd_out, 7);
    end
`ifdef GCD_ITER_COUNT_EN
    chk("hs iter", iter_count, 4);
`endif
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs release valid", out_valid, 0);
    chk("hs release in_ready", in_ready, 1);
    chk("hs idle gcd hold", gcd_out, 7);

    // Back-to-back with both handshakes tied high
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a_in = 8'd35; b_in = 8'd14;
    @(posedge clk); #1;
    a_in = 8'd17; b_in = 8'd5;
    wait_done();
    chk("b2b first latency", cyc, 5);
    chk("b2b first gcd", gcd_out, 7);
    @(posedge clk); #1;
    chk("b2b done one cycle", out_valid, 0);
    chk("b2b idle gap", in_ready, 1);
    @(posedge clk); #1;
    chk("b2b second accept", in_ready, 0);
    wait_done();
    chk("b2b second latency", cyc, 9);
    chk("b2b second gcd", gcd_out, 1);
`ifdef GCD_ITER_COUNT_EN
    chk("b2b second iter", iter_count, 8);
`endif
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b final idle", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
